// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit and the ID decoder.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package mul_div_unit_pkg;

    localparam int MD_W = 16;

    // Operation select, valid together with start.
    typedef enum logic [1:0] {
        MD_MULL = 2'b00,
        MD_MULH = 2'b01,
        MD_DIV  = 2'b10,
        MD_REM  = 2'b11
    } md_op_t;

    // Control FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } md_state_t;

endpackage

// File: rtl/mul_div_unit_md_step.sv
// One iteration of shift-add multiply or restoring divide on {hi, lo}.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the outputs.
module md_step (
    input  logic        is_div,
    input  logic [15:0] hi,
    input  logic [15:0] lo,
    input  logic [15:0] opnd,
    output logic [15:0] hi_nxt,
    output logic [15:0] lo_nxt
);

    logic [16:0] sum;
    logic [16:0] trial;

    // Multiply: add multiplicand into hi when lo[0] is set, then shift the
    // 33-bit {carry, hi, lo} right by one. Divide: shift the next dividend bit
    // into the partial remainder and trial-subtract the divisor. Because the
    // partial remainder always stays below the divisor, bit 16 of the trial
    // difference is exactly the borrow.
    always_comb begin
        sum    = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : 17'd0);
        trial  = {hi, lo[15]} - {1'b0, opnd};
        hi_nxt = sum[16:1];
        lo_nxt = {sum[0], lo[15:1]};
        if (is_div) begin
            if (trial[16]) begin
                hi_nxt = {hi[14:0], lo[15]};
                lo_nxt = {lo[14:0], 1'b0};
            end else begin
                hi_nxt = trial[15:0];
                lo_nxt = {lo[14:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 16-bit unsigned MUL/MULH/DIV/REM beside the EX-stage ALU.
// Latency: start in cycle N -> 16 iteration cycles -> md_done/result in N+17.
// Backpressure: stall_md holds the front end while busy; hold keeps DONE stable.
module mul_div_unit
    import mul_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] src0,
    input  logic [15:0] src1,
    input  logic        hold,
    input  logic        flush,
    output logic        stall_md,
    output logic [15:0] result,
    output logic        md_done,
    output logic        dbz
);

    md_state_t   state;
    md_state_t   state_nxt;
    md_op_t      op_q;
    logic [3:0]  cnt;
    logic [15:0] opnd;
    logic [15:0] acc_hi;
    logic [15:0] acc_lo;
    logic [15:0] hi_nxt;
    logic [15:0] lo_nxt;
    logic        is_div;
    logic        launch;
    logic        iterate;

    assign is_div  = (op_q == MD_DIV) || (op_q == MD_REM);
    assign launch  = (state == ST_IDLE) && start && !flush;
    assign iterate = (state == ST_BUSY) && !flush;

    md_step u_step (
        .is_div (is_div),
        .hi     (acc_hi),
        .lo     (acc_lo),
        .opnd   (opnd),
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: flush beats everything; DONE is left only when EX->DM moves.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start)         state_nxt = ST_BUSY;
                ST_BUSY: if (cnt == 4'd15)  state_nxt = ST_DONE;
                ST_DONE: if (!hold)         state_nxt = ST_IDLE;
                default:                    state_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs: stall from the issuing cycle on, released at once by flush.
    always_comb begin
        stall_md = !flush && (((state == ST_IDLE) && start) || (state == ST_BUSY));
        md_done  = (state == ST_DONE);
    end

    // Datapath: operands captured only at launch, so bypass changes during
    // BUSY are ignored. Multiply keeps the multiplier in acc_lo and adds the
    // multiplicand; divide keeps the dividend in acc_lo and subtracts the
    // divisor. Either way the last step leaves the high word (MULH/REM) in
    // hi_nxt and the low word (MULL/DIV) in lo_nxt, so op[0] picks the half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= MD_MULL;
            cnt    <= 4'd0;
            opnd   <= 16'd0;
            acc_hi <= 16'd0;
            acc_lo <= 16'd0;
            result <= 16'd0;
            dbz    <= 1'b0;
        end else if (launch) begin
            op_q   <= md_op_t'(op);
            cnt    <= 4'd0;
            acc_hi <= 16'd0;
            if (op[1]) begin
                opnd   <= src1;
                acc_lo <= src0;
            end else begin
                opnd   <= src0;
                acc_lo <= src1;
            end
        end else if (iterate) begin
            acc_hi <= hi_nxt;
            acc_lo <= lo_nxt;
            cnt    <= cnt + 4'd1;
            if (cnt == 4'd15) begin
                result <= (op_q == MD_MULH || op_q == MD_REM) ? hi_nxt : lo_nxt;
                dbz    <= is_div && (opnd == 16'd0);
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: latency, results, hold, flush and reset.
// Latency: each operation is expected to stall 17 cycles and finish in N+17.
// Backpressure: hold and flush are driven directly by the bench.
module tb_mul_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [15:0] src0;
    logic [15:0] src1;
    logic        hold;
    logic        flush;
    logic        stall_md;
    logic [15:0] result;
    logic        md_done;
    logic        dbz;

    int errors = 0;
    int checks = 0;

    mul_div_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .src0     (src0),
        .src1     (src1),
        .hold     (hold),
        .flush    (flush),
        .stall_md (stall_md),
        .result   (result),
        .md_done  (md_done),
        .dbz      (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one operation at the next negedge and follow it to DONE.
    // Operand buses are scrambled once BUSY starts; they must be ignored.
    task automatic do_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_r, input logic exp_dbz, input string tag);
        int stalls;
        int lat;
        bit got;
        stalls = 0;
        lat    = 0;
        got    = 1'b0;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src0  = a;
        src1  = b;
        for (int i = 0; i < 40 && !got; i++) begin
            #1;
            if (md_done) begin
                got = 1'b1;
            end else begin
                if (stall_md) stalls++;
                lat++;
                @(negedge clk);
                if (i == 0) begin
                    src0 = ~a;
                    src1 = a ^ b ^ 16'h5A5A;
                end
            end
        end
        chk({tag, "_lat"},    lat,      17);
        chk({tag, "_stalls"}, stalls,   17);
        chk({tag, "_result"}, result,   exp_r);
        chk({tag, "_dbz"},    dbz,      exp_dbz);
        chk({tag, "_stall0"}, stall_md, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        src0  = 16'h0000;
        src1  = 16'h0000;
        hold  = 1'b0;
        flush = 1'b0;

        // Reset state; stall_md follows start while in reset.
        #2;
        chk("rst_result",  result,   16'h0000);
        chk("rst_done",    md_done,  1'b0);
        chk("rst_dbz",     dbz,      1'b0);
        chk("rst_stall",   stall_md, 1'b0);
        start = 1'b1;
        #1;
        chk("rst_stall_start", stall_md, 1'b1);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Multiply, issued back-to-back.
        do_op(2'b00, 16'h1234, 16'h0010, 16'h2340, 1'b0, "mull_1234");
        do_op(2'b01, 16'h1234, 16'h0010, 16'h0001, 1'b0, "mulh_1234");
        do_op(2'b00, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, "mull_ffff");
        do_op(2'b01, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, "mulh_ffff");
        do_op(2'b00, 16'h1234, 16'h0000, 16'h0000, 1'b0, "mull_zero");

        // Divide, including divide by zero.
        do_op(2'b10, 16'h0064, 16'h0007, 16'h000E, 1'b0, "div_100_7");
        do_op(2'b11, 16'h0064, 16'h0007, 16'h0002, 1'b0, "rem_100_7");
        do_op(2'b10, 16'h0050, 16'h0000, 16'hFFFF, 1'b1, "div_by0");
        do_op(2'b11, 16'h0050, 16'h0000, 16'h0050, 1'b1, "rem_by0");

        // Hold in DONE with start still high: no restart, result stable.
        do_op(2'b00, 16'h0003, 16'h0005, 16'h000F, 1'b0, "mull_3_5");
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("hold_done",   md_done,  1'b1);
            chk("hold_result", result,   16'h000F);
            chk("hold_stall",  stall_md, 1'b0);
        end
        hold  = 1'b0;
        start = 1'b0;
        @(negedge clk);
        #1;
        chk("hold_exit_done",  md_done,  1'b0);
        chk("hold_exit_stall", stall_md, 1'b0);

        // Flush on the fifth BUSY cycle.
        @(negedge clk);
        start = 1'b1;
        op    = 2'b10;
        src0  = 16'h0064;
        src1  = 16'h0007;
        repeat (5) @(negedge clk);
        #1;
        chk("flush_pre_stall", stall_md, 1'b1);
        flush = 1'b1;
        #1;
        chk("flush_stall_now", stall_md, 1'b0);
        chk("flush_done_now",  md_done,  1'b0);
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        #1;
        chk("flush_idle_done",  md_done,  1'b0);
        chk("flush_idle_stall", stall_md, 1'b0);
        chk("flush_keep_result", result,  16'h000F);
        do_op(2'b11, 16'h0064, 16'h0007, 16'h0002, 1'b0, "rem_after_flush");

        // Flush while issuing from IDLE: nothing starts.
        hold = 1'b0;
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        op    = 2'b00;
        #1;
        chk("flush_idle_issue_stall", stall_md, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        #1;
        chk("flush_idle_issue_notbusy", stall_md, 1'b0);

        // Reset in the middle of BUSY, then a DIV right after release.
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        src0  = 16'h00FF;
        src1  = 16'h0101;
        repeat (6) @(negedge clk);
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_result", result,   16'h0000);
        chk("midrst_done",   md_done,  1'b0);
        chk("midrst_stall",  stall_md, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(2'b10, 16'hFFFF, 16'h0010, 16'h0FFF, 1'b0, "div_after_rst");
        start = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
